// File: rtl/detect_seq_pkg.sv
// detect_seq_pkg: shared FSM state encoding and pattern-length mask helper
package detect_seq_pkg;
  typedef enum logic [1:0] {DISABLED = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
  localparam int MASK_W = 64;
  // Saturates at MASK_W so len == full width never shifts out of range
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    return len >= MASK_W ? '1 : (64'd1 << len) - 64'd1;
  endfunction
endpackage

// File: rtl/detect_sequence_configurable_fsm_sat_counter.sv
// sat_counter: saturating up-counter; clr wins but a coincident inc still counts once
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (clr) count <= CNT_W'(inc);
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/detect_sequence_configurable_fsm.sv
// detect_sequence_configurable_fsm: run-time configurable serial pattern detector with match counter
module detect_sequence_configurable_fsm
  import detect_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic               a_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);
  state_t state;
  logic [MAX_LEN-1:0] history, pattern, shifted;
  logic [MASK_W-1:0] full_mask;
  logic [LW-1:0] len, fill, fill_next;
  logic overlap, consume, match, cfg_bad;
  always_comb begin
    shifted = {history[MAX_LEN-2:0], a};
    full_mask = len_mask(32'(len));
    consume = a_valid && !cfg_load && state != DISABLED;
    fill_next = fill == LW'(MAX_LEN) ? fill : fill + 1'b1;
    match = consume && ((shifted ^ pattern) & full_mask[MAX_LEN-1:0]) == '0 && fill_next >= len;
    cfg_bad = cfg_len == '0 || cfg_len > LW'(MAX_LEN);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= DISABLED;
      history <= '0;
      fill <= '0;
      len <= '0;
      pattern <= '0;
      overlap <= 1'b0;
      detected <= 1'b0;
      cfg_err <= 1'b1;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len <= cfg_len;
      overlap <= cfg_overlap;
      history <= '0;
      fill <= '0;
      detected <= 1'b0;
      cfg_err <= cfg_bad;
      state <= cfg_bad ? DISABLED : FILL;
    end else begin
      detected <= match;
      if (consume) begin
        history <= shifted;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits
        fill <= match && !overlap ? '0 : fill_next;
        state <= match && !overlap ? FILL : fill_next >= len ? ARMED : FILL;
      end
    end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr || cfg_load),
    .count(match_count)
  );
endmodule
